// File: rtl/alarm_fsm_sequencer.sv
// Moore sequencer for the alarm clock: turns keypad digits and TIME/ALARM buttons
// into one-cycle datapath strobes and LCD source selects, with an entry timeout.
module alarm_fsm_sequencer #(
  parameter int         TIMEOUT_S = 10,
  parameter logic [3:0] NOKEY     = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       time_button,
  input  logic       alarm_button,
  output logic       shift,
  output logic       load_alarm,
  output logic       load_time,
  output logic       reset_count,
  output logic       show_new_time,
  output logic       show_alarm
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] count, count_nxt;
  logic       key_valid;
  logic       in_entry;
  logic       timeout;

  // Any non-digit code, not just NOKEY, counts as an idle keypad.
  assign key_valid = (key <= 4'd9) && (key != NOKEY);
  assign in_entry  = (state == KEY_WAITED) || (state == KEY_ENTRY);
  assign timeout   = one_second && (count == 4'(TIMEOUT_S - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SHOW_TIME;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)   state_nxt = SHOW_ALARM;
        else if (key_valid) state_nxt = KEY_STORED;
      end
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_valid)   state_nxt = KEY_ENTRY;
        else if (timeout) state_nxt = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_nxt = SET_ALARM_TIME;
        else if (time_button) state_nxt = SET_CURRENT_TIME;
        else if (key_valid)   state_nxt = KEY_STORED;
        else if (timeout)     state_nxt = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_nxt = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_nxt = SHOW_TIME;
      SET_CURRENT_TIME: state_nxt = SHOW_TIME;
      default:          state_nxt = SHOW_TIME;
    endcase
  end

  // Inactivity is measured from key release, so the count restarts on entry to KEY_ENTRY.
  always_comb begin
    count_nxt = '0;
    if (in_entry && !(state == KEY_WAITED && state_nxt == KEY_ENTRY)) begin
      count_nxt = one_second ? count + 4'd1 : count;
    end
  end

  always_comb begin
    shift         = 1'b0;
    load_alarm    = 1'b0;
    load_time     = 1'b0;
    reset_count   = 1'b0;
    show_new_time = 1'b0;
    show_alarm    = 1'b0;
    case (state)
      KEY_STORED:       shift = 1'b1;
      KEY_WAITED:       show_new_time = 1'b1;
      KEY_ENTRY:        show_new_time = 1'b1;
      SHOW_ALARM:       show_alarm = 1'b1;
      SET_ALARM_TIME:   load_alarm = 1'b1;
      SET_CURRENT_TIME: begin
        load_time   = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_fsm_sequencer.sv
// Directed bench for alarm_fsm_sequencer: a vector table plus hand-written
// multi-cycle sequences for hold, timeout and reset corner cases.
module tb_alarm_fsm_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'hA;
  logic       time_button = 1'b0;
  logic       alarm_button = 1'b0;
  logic       shift, load_alarm, load_time, reset_count, show_new_time, show_alarm;

  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;
  int load_cnt = 0;

  // Output vector order: {shift, load_alarm, load_time, reset_count, show_new_time, show_alarm}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_SH   = 6'b100000;
  localparam logic [5:0] O_LA   = 6'b010000;
  localparam logic [5:0] O_LT   = 6'b001100;
  localparam logic [5:0] O_SNT  = 6'b000010;
  localparam logic [5:0] O_SA   = 6'b000001;

  alarm_fsm_sequencer dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key(key),
    .time_button(time_button), .alarm_button(alarm_button),
    .shift(shift), .load_alarm(load_alarm), .load_time(load_time),
    .reset_count(reset_count), .show_new_time(show_new_time), .show_alarm(show_alarm)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (shift) shift_cnt++;
    if (load_alarm || load_time) load_cnt++;
  end

  typedef struct {
    logic [3:0] k;
    logic       tb;
    logic       ab;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[28];

  function automatic logic [5:0] outs();
    return {shift, load_alarm, load_time, reset_count, show_new_time, show_alarm};
  endfunction

  task automatic chk(input string nm, input logic [5:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: outputs=%b expected=%b at %0t", nm, outs(), exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_chk(input string nm, input logic [5:0] exp);
    one_second = 1'b1;
    step();
    chk(nm, exp);
    one_second = 1'b0;
  endtask

  // Drives SHOW_TIME -> digit -> release, leaving the FSM in KEY_ENTRY with count 0.
  task automatic enter_digit(input logic [3:0] d);
    key = d;   step(); chk("enter_shift", O_SH);
    key = 4'hA; step(); chk("enter_waited", O_SNT);
    step(); chk("enter_entry", O_SNT);
  endtask

  // Ten ticks from KEY_ENTRY: display holds through tick 9, SHOW_TIME right after tick 10.
  task automatic timeout_run(input string nm);
    for (int i = 1; i <= 10; i++) begin
      tick_chk(nm, (i < 10) ? O_SNT : O_NONE);
      step();
    end
  endtask

  int s0, l0;

  initial begin
    vecs = '{
      '{4'hA,0,0,O_NONE}, '{4'hF,0,0,O_NONE}, '{4'hC,0,0,O_NONE}, '{4'h3,0,0,O_SH},
      '{4'h3,0,0,O_SNT},  '{4'h3,0,0,O_SNT},  '{4'hA,0,0,O_SNT},  '{4'h5,0,0,O_SH},
      '{4'hA,0,0,O_SNT},  '{4'hA,0,0,O_SNT},  '{4'hA,0,1,O_LA},   '{4'hA,0,1,O_NONE},
      '{4'hA,0,1,O_SA},   '{4'hA,0,0,O_NONE}, '{4'h9,0,0,O_SH},   '{4'hA,0,0,O_SNT},
      '{4'hA,0,0,O_SNT},  '{4'h5,1,0,O_LT},   '{4'hA,0,0,O_NONE}, '{4'h0,0,0,O_SH},
      '{4'h0,0,1,O_SNT},  '{4'hF,0,0,O_SNT},  '{4'hA,1,1,O_LA},   '{4'hA,0,0,O_NONE},
      '{4'h4,0,1,O_SA},   '{4'h2,0,1,O_SA},   '{4'hA,0,0,O_NONE}, '{4'hA,1,0,O_NONE}
    };

    #1 chk("reset_outputs", O_NONE);
    step(); chk("reset_held", O_NONE);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      key = vecs[i].k; time_button = vecs[i].tb; alarm_button = vecs[i].ab;
      step();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end
    key = 4'hA; time_button = 1'b0; alarm_button = 1'b0;
    step(); chk("vec_idle", O_NONE);

    // Long hold of one digit, then a second digit: one shift each.
    s0 = shift_cnt;
    key = 4'h3;
    for (int i = 0; i < 20; i++) begin
      step(); chk("hold3", (i == 0) ? O_SH : O_SNT);
    end
    key = 4'hA; step(); chk("hold_release", O_SNT);
    key = 4'h7;
    for (int i = 0; i < 3; i++) begin
      step(); chk("hold7", (i == 0) ? O_SH : O_SNT);
    end
    key = 4'hA; step(); chk("hold7_release", O_SNT);
    chk_int("hold_shift_count", shift_cnt - s0, 2);
    time_button = 1'b1; key = 4'h5; step(); chk("time_load", O_LT);
    time_button = 1'b0; key = 4'hA; step(); chk("time_load_done", O_NONE);

    // Alarm display held 8 cycles with a digit pressed mid-hold.
    s0 = shift_cnt;
    alarm_button = 1'b1;
    for (int i = 0; i < 8; i++) begin
      key = (i >= 2 && i <= 4) ? 4'h2 : 4'hA;
      step(); chk("alarm_hold", O_SA);
    end
    alarm_button = 1'b0; key = 4'hA; step(); chk("alarm_release", O_NONE);
    chk_int("alarm_hold_shift", shift_cnt - s0, 0);

    // Abandoned entry after 10 idle ticks; no load strobe.
    l0 = load_cnt;
    enter_digit(4'h8);
    timeout_run("timeout_entry");
    chk_int("timeout_no_load", load_cnt - l0, 0);

    // Digit on the 10th tick wins over timeout; ticks in KEY_WAITED do not carry over.
    enter_digit(4'h8);
    for (int i = 1; i <= 9; i++) begin
      tick_chk("pre_digit_tick", O_SNT);
      step();
    end
    key = 4'h1;
    tick_chk("digit_on_tick10", O_SH);
    step(); chk("digit_on_tick10_wait", O_SNT);
    for (int i = 0; i < 3; i++) begin
      tick_chk("waited_tick", O_SNT);
      step();
    end
    key = 4'hA; step(); chk("waited_release", O_SNT);
    timeout_run("timeout_after_waited");
    chk_int("timeout2_no_load", load_cnt - l0, 0);

    // Timeout while the digit is still held in KEY_WAITED.
    key = 4'h3; step(); chk("wt_shift", O_SH);
    step(); chk("wt_waited", O_SNT);
    for (int i = 1; i <= 10; i++) begin
      tick_chk("waited_timeout", (i < 10) ? O_SNT : O_NONE);
      if (i == 10) key = 4'hA;
      step();
    end
    chk("waited_timeout_idle", O_NONE);

    // Asynchronous reset in the middle of an entry.
    l0 = load_cnt;
    enter_digit(4'h6);
    for (int i = 0; i < 5; i++) begin
      tick_chk("pre_reset_tick", O_SNT);
      step();
    end
    #2 reset = 1'b1;
    #1 chk("async_reset", O_NONE);
    step(); chk("reset_mid_held", O_NONE);
    reset = 1'b0;
    step(); chk("post_reset_state", O_NONE);
    chk_int("reset_no_load", load_cnt - l0, 0);
    enter_digit(4'h4);
    timeout_run("post_reset_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
